// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the ID-stage decoder/pipeline registers
// and the hazard controller.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             id_rs1_used;
   logic             id_rs2_used;
   logic [4:0]       id_rd;
   logic             id_rf_we;
   logic [1:0]       id_wd_sel;
   logic             ex_redirect;
   logic             mem_busy;
   logic             stall_if;
   logic             stall_id;
   logic             stall_ex;
   logic             stall_mem;
   logic             flush_id;
   logic             bubble_ex;
   logic [1:0]       fwd_a_sel;
   logic [1:0]       fwd_b_sel;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_valid, id_rs1, id_rs2,
      output id_rs1_used, id_rs2_used,
      output id_rd, id_rf_we, id_wd_sel,
      output ex_redirect, mem_busy,
      input  stall_if, stall_id,
      input  stall_ex, stall_mem,
      input  flush_id, bubble_ex,
      input  fwd_a_sel, fwd_b_sel,
      input  stall_cnt, flush_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2,
      input  id_rs1_used, id_rs2_used,
      input  id_rd, id_rf_we, id_wd_sel,
      input  ex_redirect, mem_busy,
      output stall_if, stall_id,
      output stall_ex, stall_mem,
      output flush_id, bubble_ex,
      output fwd_a_sel, fwd_b_sel,
      output stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/bubble sequencing and registered forwarding selects
// for the 5-stage RV32I pipeline.
module pipeline_hazard_ctrl #(
   parameter int         CNT_W            = 16,
   parameter logic [1:0] WD_SEL_FROM_DRAM = 2'd1
) (
   input logic                     clk,
   input logic                     rst_n,
   pipeline_hazard_ctrl_if.slave   bus
);

   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      logic       we;
      logic       ld;
   } rec_t;

   rec_t             ex_q, ex_d;
   rec_t             mem_q, mem_d;
   rec_t             id_rec;
   logic [1:0]       fwd_a_q, fwd_a_d;
   logic [1:0]       fwd_b_q, fwd_b_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic freeze, redir, ld_use, lu;
   logic ex_a, ex_b, mem_a, mem_b;

   function automatic logic hit(
      input rec_t       r,
      input logic [4:0] rs,
      input logic       used
   );
      return r.v && r.we && (r.rd != 5'd0)
         && (r.rd == rs) && used;
   endfunction

   always_comb begin
      id_rec.v  = bus.id_valid;
      id_rec.rd = bus.id_rd;
      id_rec.we = bus.id_rf_we
         && (bus.id_rd != 5'd0);
      id_rec.ld = (bus.id_wd_sel == WD_SEL_FROM_DRAM);

      ex_a  = hit(ex_q, bus.id_rs1, bus.id_rs1_used);
      ex_b  = hit(ex_q, bus.id_rs2, bus.id_rs2_used);
      mem_a = hit(mem_q, bus.id_rs1, bus.id_rs1_used);
      mem_b = hit(mem_q, bus.id_rs2, bus.id_rs2_used);

      ld_use = bus.id_valid && ex_q.ld && (ex_a || ex_b);
      freeze = bus.mem_busy;
      redir  = !freeze && bus.ex_redirect;
      lu     = !freeze && !redir && ld_use;
   end

   assign bus.stall_if  = freeze || lu;
   assign bus.stall_id  = freeze || lu;
   assign bus.stall_ex  = freeze;
   assign bus.stall_mem = freeze;
   assign bus.flush_id  = redir;
   assign bus.bubble_ex = redir || lu;
   assign bus.fwd_a_sel = fwd_a_q;
   assign bus.fwd_b_sel = fwd_b_q;
   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;

   always_comb begin
      ex_d    = ex_q;
      mem_d   = mem_q;
      fwd_a_d = fwd_a_q;
      fwd_b_d = fwd_b_q;
      unique case (1'b1)
         freeze: begin
         end
         redir, lu: begin
            ex_d    = '0;
            mem_d   = ex_q;
            fwd_a_d = 2'd0;
            fwd_b_d = 2'd0;
         end
         default: begin
            ex_d    = id_rec;
            mem_d   = ex_q;
            // EX result beats MEM; a matching EX load never gets here
            fwd_a_d = (ex_a && !ex_q.ld) ? 2'd1
                    : mem_a ? 2'd2 : 2'd0;
            fwd_b_d = (ex_b && !ex_q.ld) ? 2'd1
                    : mem_b ? 2'd2 : 2'd0;
         end
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (bus.stall_if && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 1'b1;
      if (bus.flush_id && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q        <= '0;
         mem_q       <= '0;
         fwd_a_q     <= 2'd0;
         fwd_b_q     <= 2'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         fwd_a_q     <= fwd_a_d;
         fwd_b_q     <= fwd_b_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl: forwarding,
// load-use, redirect, freeze, counter saturation and async reset.
module tb_pipeline_hazard_ctrl;

   localparam logic [1:0] WD_DRAM = 2'd1;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   pipeline_hazard_ctrl_if #(.CNT_W(16)) bus ();

   pipeline_hazard_ctrl #(
      .CNT_W            (16),
      .WD_SEL_FROM_DRAM (WD_DRAM)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // {stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex}
   task automatic chk_ctl(input string tag, input logic [5:0] exp);
      chk(tag, int'({bus.stall_if, bus.stall_id, bus.stall_ex,
                     bus.stall_mem, bus.flush_id, bus.bubble_ex}),
          int'(exp));
   endtask

   task automatic chk_fwd(input string tag, input int a, input int b);
      chk({tag, "_a"}, int'(bus.fwd_a_sel), a);
      chk({tag, "_b"}, int'(bus.fwd_b_sel), b);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic id_set(
      input logic       v,
      input logic [4:0] rs1,
      input logic       u1,
      input logic [4:0] rs2,
      input logic       u2,
      input logic [4:0] rd,
      input logic       we,
      input logic       ld
   );
      bus.id_valid    = v;
      bus.id_rs1      = rs1;
      bus.id_rs1_used = u1;
      bus.id_rs2      = rs2;
      bus.id_rs2_used = u2;
      bus.id_rd       = rd;
      bus.id_rf_we    = we;
      bus.id_wd_sel   = ld ? WD_DRAM : 2'd0;
      #1;
   endtask

   task automatic id_idle();
      id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.ex_redirect = 1'b0;
      bus.mem_busy    = 1'b0;
      id_idle();
      chk_ctl("rst_ctl", 6'b000000);
      chk_fwd("rst_fwd", 0, 0);
      chk("rst_scnt", int'(bus.stall_cnt), 0);
      chk("rst_fcnt", int'(bus.flush_cnt), 0);
      #2 rst_n = 1'b1;
      step();

      // add x5,x1,x2 ; sub x6,x5,x1 ; or x11,x5,x3
      id_set(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
      chk_ctl("add_ctl", 6'b000000);
      step();
      id_set(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
      chk_ctl("sub_ctl", 6'b000000);
      step();
      chk_fwd("sub_fwd", 1, 0);
      id_set(1, 5'd5, 1, 5'd3, 1, 5'd11, 1, 0);
      chk_ctl("or_ctl", 6'b000000);
      step();
      chk_fwd("or_fwd", 2, 0);
      id_idle();
      step();

      // lw x7,0(x2) ; add x8,x7,x7
      id_set(1, 5'd2, 1, 5'd0, 0, 5'd7, 1, 1);
      chk_ctl("lw_ctl", 6'b000000);
      step();
      id_set(1, 5'd7, 1, 5'd7, 1, 5'd8, 1, 0);
      chk_ctl("lu_ctl", 6'b110001);
      step();
      chk_ctl("lu_after", 6'b000000);
      chk_fwd("lu_bub", 0, 0);
      chk("lu_scnt", int'(bus.stall_cnt), 1);
      step();
      chk_fwd("lu_fwd", 2, 2);
      id_idle();
      step();

      // lw x0 then reader of x0
      id_set(1, 5'd2, 1, 5'd0, 0, 5'd0, 1, 1);
      step();
      id_set(1, 5'd0, 1, 5'd0, 1, 5'd1, 1, 0);
      chk_ctl("x0_ctl", 6'b000000);
      step();
      // lw x12 then lui x9 whose rs1 field is 12 but unused
      id_set(1, 5'd3, 1, 5'd0, 0, 5'd12, 1, 1);
      step();
      id_set(1, 5'd12, 0, 5'd12, 0, 5'd9, 1, 0);
      chk_ctl("lui_ctl", 6'b000000);
      step();
      chk("unused_scnt", int'(bus.stall_cnt), 1);

      // redirect coinciding with load-use
      id_set(1, 5'd2, 1, 5'd0, 0, 5'd13, 1, 1);
      step();
      id_set(1, 5'd13, 1, 5'd0, 0, 5'd14, 1, 0);
      bus.ex_redirect = 1'b1;
      #1;
      chk_ctl("rd_lu_ctl", 6'b000011);
      step();
      bus.ex_redirect = 1'b0;
      chk("rd_fcnt", int'(bus.flush_cnt), 1);
      chk("rd_scnt", int'(bus.stall_cnt), 1);
      chk_fwd("rd_fwd", 0, 0);

      // set up fwd_a=1 then freeze with redirect pending
      id_set(1, 5'd1, 1, 5'd0, 0, 5'd15, 1, 0);
      step();
      id_set(1, 5'd15, 1, 5'd0, 1, 5'd16, 1, 0);
      step();
      chk_fwd("pre_frz", 1, 0);
      id_idle();
      bus.mem_busy    = 1'b1;
      bus.ex_redirect = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk_ctl("frz_ctl", 6'b111100);
         step();
      end
      chk_fwd("frz_hold", 1, 0);
      chk("frz_scnt", int'(bus.stall_cnt), 4);
      chk("frz_fcnt", int'(bus.flush_cnt), 1);
      bus.mem_busy = 1'b0;
      #1;
      chk_ctl("post_frz", 6'b000011);
      step();
      bus.ex_redirect = 1'b0;
      chk("post_fcnt", int'(bus.flush_cnt), 2);
      chk_fwd("post_fwd", 0, 0);

      // saturation: 4 + 65541 stall cycles
      id_set(1, 5'd1, 1, 5'd0, 0, 5'd17, 1, 0);
      step();
      id_set(1, 5'd17, 1, 5'd0, 0, 5'd18, 1, 0);
      step();
      id_idle();
      bus.mem_busy = 1'b1;
      repeat (65541) step();
      chk("sat_scnt", int'(bus.stall_cnt), 16'hFFFF);
      chk_fwd("sat_fwd", 1, 0);

      // async reset mid-freeze, no clock edge
      #2;
      bus.mem_busy = 1'b0;
      rst_n        = 1'b0;
      #1;
      chk_ctl("arst_ctl", 6'b000000);
      chk_fwd("arst_fwd", 0, 0);
      chk("arst_scnt", int'(bus.stall_cnt), 0);
      chk("arst_fcnt", int'(bus.flush_cnt), 0);
      #2 rst_n = 1'b1;
      step();
      // cleared records: consumer of x18 gets no forwarding
      id_set(1, 5'd18, 1, 5'd17, 1, 5'd19, 1, 0);
      step();
      chk_fwd("arst_rec", 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
